// File: rtl/regfile_mp_if.sv
// regfile_mp_if: read, write and scoreboard bus of the multi-port register file.
// The issue stage is the master; the register file is the slave.
interface regfile_mp_if #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 2
);
    localparam int ADDR_W = $clog2(DEPTH);

    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_ready;
    logic [NUM_WR-1:0]        wr_en;
    logic [NUM_WR*ADDR_W-1:0] wr_addr;
    logic [NUM_WR*DATA_W-1:0] wr_data;
    logic                     rsv_en;
    logic [ADDR_W-1:0]        rsv_addr;
    logic [DEPTH-1:0]         pending;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
        input  rd_data, rd_ready, pending
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
        output rd_data, rd_ready, pending
    );
endinterface

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port register file with a per-register pending scoreboard.
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 32,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic        clk,
    input  logic        rst,
    regfile_mp_if.slave bus
);
    localparam int ADDR_W = $clog2(DEPTH);

    typedef logic [ADDR_W-1:0] addrT;

    logic [DATA_W-1:0]        regsQ [DEPTH];
    logic [DEPTH-1:0]         pendingQ;
    logic [DEPTH-1:0]         wrHit;
    logic [DEPTH-1:0]         rsvHit;
    logic [DATA_W-1:0]        wrVal [DEPTH];
    addrT                     rdA [NUM_RD];
    logic [NUM_RD*DATA_W-1:0] rdData;
    logic [NUM_RD-1:0]        rdReady;
`ifdef REGFILE_BYPASS_EN
    logic [NUM_RD-1:0]        fwdHit;
`endif

    function automatic logic isZeroAddr(addrT a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    // Per-register write/reserve decode; ascending port scan lets the highest index win.
    always_comb begin
        wrHit  = '0;
        rsvHit = '0;
        for (int r = 0; r < DEPTH; r++) begin
            wrVal[r] = '0;
            for (int j = 0; j < NUM_WR; j++) begin
                if (bus.wr_en[j] && (bus.wr_addr[j*ADDR_W +: ADDR_W] == addrT'(r)) &&
                    !isZeroAddr(addrT'(r))) begin
                    wrHit[r] = 1'b1;
                    wrVal[r] = bus.wr_data[j*DATA_W +: DATA_W];
                end
            end
            rsvHit[r] = bus.rsv_en && (bus.rsv_addr == addrT'(r)) && !isZeroAddr(addrT'(r));
        end
    end

    // Storage and scoreboard: reset wins; a reserve beats a same-cycle write release.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < DEPTH; r++) begin
                regsQ[r] <= '0;
            end
            pendingQ <= '0;
        end else begin
            for (int r = 0; r < DEPTH; r++) begin
                if (wrHit[r]) begin
                    regsQ[r] <= wrVal[r];
                end
            end
            pendingQ <= rsvHit | (pendingQ & ~wrHit);
        end
    end

    // Unpack read addresses.
    always_comb begin
        for (int i = 0; i < NUM_RD; i++) begin
            rdA[i] = bus.rd_addr[i*ADDR_W +: ADDR_W];
        end
    end

    // Combinational read ports with optional forwarding of this cycle's writes.
    always_comb begin
        rdData  = '0;
        rdReady = '0;
`ifdef REGFILE_BYPASS_EN
        fwdHit  = '0;
`endif
        for (int i = 0; i < NUM_RD; i++) begin
            rdData[i*DATA_W +: DATA_W] = regsQ[rdA[i]];
            rdReady[i]                 = ~pendingQ[rdA[i]];
`ifdef REGFILE_BYPASS_EN
            if (!rst) begin
                for (int j = 0; j < NUM_WR; j++) begin
                    if (bus.wr_en[j] && (bus.wr_addr[j*ADDR_W +: ADDR_W] == rdA[i])) begin
                        fwdHit[i]                  = 1'b1;
                        rdData[i*DATA_W +: DATA_W] = bus.wr_data[j*DATA_W +: DATA_W];
                    end
                end
                // The forwarded value is ready unless a new producer reserves it right now.
                if (fwdHit[i]) begin
                    rdReady[i] = !(bus.rsv_en && (bus.rsv_addr == rdA[i]));
                end
            end
`endif
            if (isZeroAddr(rdA[i])) begin
                rdData[i*DATA_W +: DATA_W] = '0;
                rdReady[i]                 = 1'b1;
            end
        end
    end

    assign bus.rd_data  = rdData;
    assign bus.rd_ready = rdReady;
    assign bus.pending  = pendingQ;
endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port register file: next generation of the dual-write, dual-read CPU register array.
- Configurable data width, depth, read-port count and write-port count; optional hardwired zero register.
- Synchronous reset clears all registers.
- Per-register pending scoreboard (reserve/write-release) lets the issue stage detect RAW hazards against in-flight producers.

Parameters:
- DATA_W, 32, register data width in bits
- DEPTH, 32, number of registers; power of two, >= 2
- ADDR_W, $clog2(DEPTH), register address width; derived, do not override
- NUM_RD, 2, number of read ports, 1..4
- NUM_WR, 2, number of write ports, 1..4
- ZERO_REG, 1, 1 = register 0 always reads 0 and ignores writes and reserves

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous active-high reset
- rd_addr  input  NUM_RD*ADDR_W  packed read addresses; port i at bits [i*ADDR_W +: ADDR_W]
- rd_data  output  NUM_RD*DATA_W  packed read data, combinational from rd_addr
- rd_ready  output  NUM_RD  1 = addressed register not pending
- wr_en  input  NUM_WR  per-port write enable
- wr_addr  input  NUM_WR*ADDR_W  packed write addresses
- wr_data  input  NUM_WR*DATA_W  packed write data
- rsv_en  input  1  reserve request: mark rsv_addr pending
- rsv_addr  input  ADDR_W  register to reserve
- pending  output  DEPTH  scoreboard bit per register, registered

Behaviour:
- Reset (rst=1 at posedge clk):
  - All registers become 0 and all pending bits become 0.
  - Writes and reserves in that cycle are discarded.
  - Reset has priority over every other input.
- Reset outputs: rd_data = 0 on all ports; rd_ready = all 1s; pending = 0.
- Read: rd_data[i] = regs[rd_addr[i]], combinational, zero latency.
- rd_ready[i] = ~pending[rd_addr[i]].
- Write: on posedge with wr_en[j]=1, regs[wr_addr[j]] <= wr_data[j]. Visible on reads from the next cycle.
- Write conflict: when several enabled ports target the same address, the highest-index port wins. Other ports still complete writes to other addresses.
- Scoreboard:
  - Reserve: rsv_en=1 sets pending[rsv_addr] at the next edge.
  - Write release: any enabled write to an address clears its pending bit at the next edge.
  - Same address reserved and written in one cycle: data is written and pending ends at 1 (the new producer wins).
  - Reserving an already pending register: stays 1, no error.
  - A write to a non-pending register is a legal plain write; pending stays 0.
- ZERO_REG=1:
  - Address 0 reads 0 and rd_ready is 1.
  - Writes to address 0 are dropped and do not affect conflict resolution.
  - Reserve of address 0 is ignored; pending[0] is tied to 0.
- ZERO_REG=0: address 0 is an ordinary register.
- No wrap-around or out-of-range condition exists: the address width exactly covers DEPTH.
- Reads during reset cycle: combinational from current (pre-reset) contents; reads return 0 from the cycle after.

Optional Feature:
- Macro: REGFILE_BYPASS_EN
- Defined: each read port forwards same-cycle write data.
  - If any enabled write port targets rd_addr[i] (excluding address 0 when ZERO_REG=1), rd_data[i] = wr_data of the highest-index matching port.
  - rd_ready[i] = 1 unless rsv_en also targets that address in the same cycle.
  - Forwarding is suppressed while rst=1.
- Not defined: reads return stored contents only; written data is visible from the next cycle; rd_ready reflects only registered pending bits.

Test Plan:
- Reset: preload regs 5 and 9, reserve reg 7, assert rst one cycle -> all rd_data 0, pending = 0, rd_ready all 1.
- Basic write/read: write port0 reg 3 = 0xDEADBEEF -> read port1 addr 3 returns 0xDEADBEEF the next cycle. Same-cycle read returns old value 0 without bypass, 0xDEADBEEF with REGFILE_BYPASS_EN.
- Conflict: port0 and port1 both write reg 10 (0x11111111 / 0x22222222) in one cycle -> reg 10 = 0x22222222. Port0 to reg 11 and port1 to reg 12 in one cycle -> both written.
- Zero register (ZERO_REG=1): write reg 0 = 0xFFFFFFFF and rsv_en on addr 0 -> rd_data addr 0 = 0, pending[0] = 0, rd_ready = 1.
- Scoreboard: reserve reg 4 -> rd_ready for addr 4 = 0 next cycle. Write reg 4 = 0x1234 two cycles later -> pending[4] = 0 and data 0x1234 the following cycle. Reserve and write reg 4 together -> pending[4] = 1 and data updated.
- Parameter sweep: NUM_RD=4, NUM_WR=3, DEPTH=16, DATA_W=64; random writes checked against a reference model over 1000 cycles -> zero mismatches, highest-port-wins rule holds.
